axi_sram_bridge: RTL and testbench
==================================

AXI_SRAM_BRIDGE -- requirements
Module: axi_sram_bridge

Interface
REQ-001 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-002 SHALL have parameter MEM_BYTES, default 1680, size of the populated SRAM window in bytes.
REQ-003 SHALL have port CLK, input, 1, clock.
REQ-004 SHALL have port RESETn, input, 1, reset (asynchronous, active-low).
REQ-005 SHALL have AW channel ports: AWID in ID_W; AWADDR in 32; AWLEN in 8; AWVALID in 1; AWREADY out 1.
REQ-006 SHALL have W channel ports: WDATA in 64; WSTRB in 8; WLAST in 1; WVALID in 1; WREADY out 1.
REQ-007 SHALL have B channel ports: BID out ID_W; BRESP out 2; BVALID out 1; BREADY in 1.
REQ-008 SHALL have AR channel ports: ARID in ID_W; ARADDR in 32; ARLEN in 8; ARVALID in 1; ARREADY out 1.
REQ-009 SHALL have R channel ports: RID out ID_W; RDATA out 64; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.
REQ-010 SHALL have SRAM ports, all active-low enables:
- SRAM_CEn out 1
- SRAM_ADDR out 32
- SRAM_WDATA out 64
- SRAM_WEn out 1
- SRAM_WBEn out 8
- SRAM_RDATA in 64 (registered downstream; valid 1 cycle after a read strobe and held while SRAM_CEn=1)

Function
REQ-011 SHALL implement states IDLE, WR_DATA, WR_RESP, RD_DATA, with one transaction outstanding at a time.
REQ-012 SHALL use 64-bit INCR beats only; each beat address = AxADDR with bits [2:0] forced to 0, plus 8*beat; beat count = AxLEN+1.
REQ-013 In IDLE SHALL assert AWREADY/ARREADY combinationally to the granted request; if both are valid, grant alternates, starting with write after reset.
REQ-014 AW handshake SHALL latch ID/address/length and go to WR_DATA; AR handshake SHALL latch them, issue beat 0 the same cycle, and go to RD_DATA.
REQ-015 In WR_DATA, WREADY=1; each WVALID cycle SHALL drive SRAM_CEn=0, SRAM_WEn=0, SRAM_WBEn=~WSTRB, SRAM_WDATA=WDATA, SRAM_ADDR=beat address.
REQ-016 The WLAST beat, or beat AxLEN if WLAST is absent, SHALL end the burst; further W beats stall until the next AW.
REQ-017 In WR_RESP, BVALID=1 with the latched BID; on BREADY, return to IDLE.
REQ-018 A read strobe (SRAM_CEn=0, SRAM_WEn=1) SHALL be issued when beats remain and (RVALID=0 or RREADY=1).
- Gives 1 beat/cycle at full throughput.
- RVALID rises the cycle after a strobe.
- RDATA=SRAM_RDATA.
- RLAST=1 on beat AxLEN.
- Data stays stable under backpressure.
REQ-019 The RLAST handshake SHALL return the FSM to IDLE.
REQ-020 When idle, SRAM_CEn=1, SRAM_WEn=1, SRAM_WBEn=8'hFF.
REQ-021 BRESP/RRESP SHALL be OKAY (2'b00) except as in REQ-025.

Reset
REQ-022 Reset state SHALL be: state=IDLE; BVALID=RVALID=0; RLAST=0; SRAM_CEn=1; SRAM_WEn=1; SRAM_WBEn=8'hFF; latched ID/address/length=0.
REQ-023 Reset mid-burst SHALL abandon the transaction with no B/R response and no further SRAM strobe.

Configuration
REQ-024 The macro AXI_SRAM_BRIDGE_RANGE_CHK_EN SHALL select address range checking.
REQ-025 With AXI_SRAM_BRIDGE_RANGE_CHK_EN defined:
- Beats at address >= MEM_BYTES SHALL issue no SRAM strobe.
- Such write beats are accepted and discarded; BRESP=SLVERR (2'b10) if any beat was out of range.
- Such read beats return RDATA=0 with RRESP=SLVERR.
REQ-026 Without the macro, all addresses SHALL pass through with OKAY responses.

Structure
REQ-027 Package axi_sram_pkg SHALL hold:
- state enum
- AXI response constants OKAY/SLVERR
- beat size constant 8
- default MEM_BYTES
REQ-028 There SHALL be no sub-module; the beat address counter and FSM stay in one module.

Verification
REQ-029 Write: AW addr 0x0A8, len 1, WSTRB 8'hFF/8'h0F -> two SRAM writes at 0x0A8/0x0B0 with WBEn 8'h00/8'hF0; then BRESP=OKAY with BID echoed.
REQ-030 Read: AR addr 0x150, len 3, RREADY=1 -> strobes on 4 consecutive cycles at 0x150..0x168; RLAST on beat 4.
REQ-031 Read backpressure: RREADY low 3 cycles on beat 1 -> RDATA stable, SRAM_CEn=1 throughout, no beat lost.
REQ-032 Simultaneous AWVALID/ARVALID after reset -> write granted first, then read; repeated collisions alternate.
REQ-033 With AXI_SRAM_BRIDGE_RANGE_CHK_EN: read at 0x690 -> no strobe, RDATA=0, RRESP=SLVERR; write there -> BRESP=SLVERR.
REQ-034 RESETn low during beat 2 of a len-7 read -> RVALID=0 and SRAM_CEn=1 immediately; next AR handled normally.

Source files
------------

// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI4 to single-port SRAM bridge.
package axi_sram_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_DATA = 2'd1,
      WR_RESP = 2'd2,
      RD_DATA = 2'd3
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int BEAT_BYTES        = 8;
   localparam int MEM_BYTES_DEFAULT = 1680;

endpackage

// File: rtl/axi_sram_bridge.sv
// AXI4 (64-bit INCR, one transaction outstanding) to synchronous SRAM bridge.
// Define AXI_SRAM_BRIDGE_RANGE_CHK_EN to suppress and SLVERR beats at or beyond MEM_BYTES.
module axi_sram_bridge
   import axi_sram_pkg::*;
#(
   parameter int ID_W      = 4,
   parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
   input  logic            CLK,
   input  logic            RESETn,
   input  logic [ID_W-1:0] AWID,
   input  logic [31:0]     AWADDR,
   input  logic [7:0]      AWLEN,
   input  logic            AWVALID,
   output logic            AWREADY,
   input  logic [63:0]     WDATA,
   input  logic [7:0]      WSTRB,
   input  logic            WLAST,
   input  logic            WVALID,
   output logic            WREADY,
   output logic [ID_W-1:0] BID,
   output logic [1:0]      BRESP,
   output logic            BVALID,
   input  logic            BREADY,
   input  logic [ID_W-1:0] ARID,
   input  logic [31:0]     ARADDR,
   input  logic [7:0]      ARLEN,
   input  logic            ARVALID,
   output logic            ARREADY,
   output logic [ID_W-1:0] RID,
   output logic [63:0]     RDATA,
   output logic [1:0]      RRESP,
   output logic            RLAST,
   output logic            RVALID,
   input  logic            RREADY,
   output logic            SRAM_CEn,
   output logic [31:0]     SRAM_ADDR,
   output logic [63:0]     SRAM_WDATA,
   output logic            SRAM_WEn,
   output logic [7:0]      SRAM_WBEn,
   input  logic [63:0]     SRAM_RDATA
);

`ifdef AXI_SRAM_BRIDGE_RANGE_CHK_EN
   localparam bit RANGE_CHK = 1'b1;
`else
   localparam bit RANGE_CHK = 1'b0;
`endif

   function automatic logic out_of_range(input logic [31:0] a);
      return RANGE_CHK && (a >= 32'(MEM_BYTES));
   endfunction

   state_t          state_q, state_d;
   logic [ID_W-1:0] id_q;
   logic [31:0]     addr_q;
   logic [7:0]      len_q;
   logic [8:0]      beat_q;
   logic            wr_prio_q, wr_err_q, rvalid_q, rlast_q, roor_q;
   logic            wr_pick, aw_hs, ar_hs, w_beat, w_last, rd_issue, r_done;
   logic [31:0]     aw_base, ar_base;

   assign aw_base  = AWADDR & ~32'h7;
   assign ar_base  = ARADDR & ~32'h7;
   // The side that won last time yields on a collision
   assign wr_pick  = AWVALID && (!ARVALID || wr_prio_q);
   assign aw_hs    = (state_q == IDLE) && wr_pick;
   assign ar_hs    = (state_q == IDLE) && ARVALID && !wr_pick;
   assign w_beat   = (state_q == WR_DATA) && WVALID;
   assign w_last   = WLAST || (beat_q[7:0] == len_q);
   assign rd_issue = (state_q == RD_DATA) && (beat_q <= {1'b0, len_q}) && (!rvalid_q || RREADY);
   assign r_done   = rvalid_q && RREADY && rlast_q;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (aw_hs) state_d = WR_DATA;
                  else if (ar_hs) state_d = RD_DATA;
         WR_DATA: if (w_beat && w_last) state_d = WR_RESP;
         WR_RESP: if (BREADY) state_d = IDLE;
         RD_DATA: if (r_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      SRAM_CEn   = 1'b1;
      SRAM_WEn   = 1'b1;
      SRAM_WBEn  = 8'hFF;
      SRAM_ADDR  = addr_q;
      SRAM_WDATA = WDATA;
      if (ar_hs) begin
         SRAM_ADDR = ar_base;
         SRAM_CEn  = out_of_range(ar_base);
      end else if (w_beat && !out_of_range(addr_q)) begin
         SRAM_CEn  = 1'b0;
         SRAM_WEn  = 1'b0;
         SRAM_WBEn = ~WSTRB;
      end else if (rd_issue) begin
         SRAM_CEn  = out_of_range(addr_q);
      end
   end

   assign AWREADY = aw_hs;
   assign ARREADY = ar_hs;
   assign WREADY  = (state_q == WR_DATA);
   assign BVALID  = (state_q == WR_RESP);
   assign BID     = id_q;
   assign BRESP   = wr_err_q ? RESP_SLVERR : RESP_OKAY;
   assign RID     = id_q;
   assign RVALID  = rvalid_q;
   assign RLAST   = rlast_q;
   assign RRESP   = roor_q ? RESP_SLVERR : RESP_OKAY;
   // SRAM holds its output while idle, so passing it straight through keeps RDATA stable under backpressure
   assign RDATA   = roor_q ? 64'd0 : SRAM_RDATA;

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         wr_prio_q <= 1'b1;
         wr_err_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         roor_q    <= 1'b0;
      end else begin
         if (aw_hs) begin
            id_q      <= AWID;
            addr_q    <= aw_base;
            len_q     <= AWLEN;
            beat_q    <= 9'd0;
            wr_err_q  <= 1'b0;
            wr_prio_q <= 1'b0;
         end else if (ar_hs) begin
            // Beat 0 goes out with the handshake, so the counters start at beat 1
            id_q      <= ARID;
            addr_q    <= ar_base + 32'(BEAT_BYTES);
            len_q     <= ARLEN;
            beat_q    <= 9'd1;
            wr_prio_q <= 1'b1;
         end else if (w_beat || rd_issue) begin
            addr_q    <= addr_q + 32'(BEAT_BYTES);
            beat_q    <= beat_q + 9'd1;
            if (w_beat) wr_err_q <= wr_err_q | out_of_range(addr_q);
         end

         if (ar_hs) begin
            rvalid_q <= 1'b1;
            rlast_q  <= (ARLEN == 8'd0);
            roor_q   <= out_of_range(ar_base);
         end else if (rd_issue) begin
            rvalid_q <= 1'b1;
            rlast_q  <= (beat_q[7:0] == len_q);
            roor_q   <= out_of_range(addr_q);
         end else if (RREADY) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed self-checking bench for axi_sram_bridge with a behavioural registered SRAM.
module tb_axi_sram_bridge;

   logic        CLK = 1'b0;
   logic        RESETn = 1'b0;
   logic [3:0]  AWID = '0, ARID = '0, BID, RID;
   logic [31:0] AWADDR = '0, ARADDR = '0, SRAM_ADDR;
   logic [7:0]  AWLEN = '0, ARLEN = '0, WSTRB = '0, SRAM_WBEn;
   logic        AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
   logic        BVALID, BREADY = 1'b0, ARVALID = 1'b0, ARREADY;
   logic        RLAST, RVALID, RREADY = 1'b0, SRAM_CEn, SRAM_WEn;
   logic [63:0] WDATA = '0, RDATA, SRAM_WDATA, sram_rdata;
   logic [1:0]  BRESP, RRESP;

   axi_sram_bridge #(.ID_W(4), .MEM_BYTES(1680)) dut (
      .CLK(CLK), .RESETn(RESETn),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
      .SRAM_CEn(SRAM_CEn), .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA), .SRAM_WEn(SRAM_WEn),
      .SRAM_WBEn(SRAM_WBEn), .SRAM_RDATA(sram_rdata)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   bit loaded = 1'b0;
   logic [63:0] mem [256];
   logic [31:0] log_addr[$];
   logic        log_wen[$];
   logic [7:0]  log_wbe[$];
   logic [63:0] log_data[$];
   int          log_cyc[$];

   // Word i preloads as {5A5A5A, i, 3C3C3C, ~i}
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] = {24'h5A5A5A, 8'(i), 24'h3C3C3C, ~8'(i)};
         loaded <= 1'b1;
      end
      if (SRAM_CEn === 1'b0) begin
         log_addr.push_back(SRAM_ADDR);
         log_wen.push_back(SRAM_WEn);
         log_wbe.push_back(SRAM_WBEn);
         log_data.push_back(SRAM_WDATA);
         log_cyc.push_back(cyc);
         if (!SRAM_WEn) begin
            for (int b = 0; b < 8; b++)
               if (!SRAM_WBEn[b]) mem[SRAM_ADDR[10:3]][8*b +: 8] = SRAM_WDATA[8*b +: 8];
         end else begin
            sram_rdata <= mem[SRAM_ADDR[10:3]];
         end
      end
   end

   logic [63:0] rd_data[$];
   logic [1:0]  rd_resp[$];
   logic        rd_last[$];
   logic [3:0]  rd_id[$];
   logic [63:0] stall_data[$];
   int          stall_cen_bad, ar_wait, aw_wait;
   bit          rd_tmo, wr_tmo;
   logic        first_aw, first_ar;
   logic [3:0]  bid_got;
   logic [1:0]  bresp_got;

   task automatic reset_dut();
      RESETn = 1'b0; AWVALID = 0; WVALID = 0; ARVALID = 0; RREADY = 0; BREADY = 0; WLAST = 0;
      repeat (3) @(posedge CLK);
      #1 RESETn = 1'b1;
   endtask

   task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [7:0] strb0, input logic [7:0] strb_n, input logic [63:0] seed);
      bit ok = 0;
      wr_tmo = 0; aw_wait = -1;
      AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1;
      for (int k = 0; k < 50 && !ok; k++) begin
         #1;
         if (k == 0) first_ar = ARREADY;
         if (AWREADY) begin ok = 1; aw_wait = k; end
         @(posedge CLK); #1;
      end
      if (!ok) wr_tmo = 1;
      AWVALID = 0;
      for (int b = 0; b <= int'(len); b++) begin
         WDATA = seed + 64'(b); WSTRB = (b == 0) ? strb0 : strb_n; WLAST = (b == int'(len)); WVALID = 1;
         ok = 0;
         for (int k = 0; k < 50 && !ok; k++) begin
            #1; ok = WREADY; @(posedge CLK); #1;
         end
         if (!ok) wr_tmo = 1;
      end
      WVALID = 0; WLAST = 0; BREADY = 1; ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
         #1;
         if (BVALID) begin ok = 1; bid_got = BID; bresp_got = BRESP; end
         @(posedge CLK); #1;
      end
      if (!ok) wr_tmo = 1;
      BREADY = 0;
   endtask

   task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input int stall_beat, input int stall_n);
      int beats = 0;
      int stalled = 0;
      bit ar_seen = 0;
      rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_id.delete(); stall_data.delete();
      stall_cen_bad = 0; rd_tmo = 1; ar_wait = -1;
      ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1; RREADY = 1;
      #1;
      first_aw = AWREADY;
      if (ARREADY) begin ar_seen = 1; ar_wait = 0; end
      for (int k = 0; k < 100; k++) begin
         @(posedge CLK); #1;
         if (ar_seen) ARVALID = 0;
         RREADY = 1;
         if (RVALID && beats == stall_beat && stalled < stall_n) begin RREADY = 0; stalled++; end
         #1;
         if (!RREADY) begin
            stall_data.push_back(RDATA);
            if (SRAM_CEn !== 1'b1) stall_cen_bad++;
         end
         if (ARVALID && ARREADY && !ar_seen) begin ar_seen = 1; ar_wait = k + 1; end
         if (RVALID && RREADY) begin
            rd_data.push_back(RDATA); rd_resp.push_back(RRESP);
            rd_last.push_back(RLAST); rd_id.push_back(RID);
            beats++;
            if (beats > int'(len)) begin rd_tmo = 0; break; end
         end
      end
      @(posedge CLK); #1;
      ARVALID = 0; RREADY = 0;
   endtask

   task automatic test_reset();
      RESETn = 1'b0;
      @(posedge CLK); #1;
      n_checks++; if (BVALID !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid: got %b expected 0", BVALID); end
      n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b expected 0", RVALID); end
      n_checks++; if (RLAST !== 1'b0) begin n_fail++; $display("FAIL rst_rlast: got %b expected 0", RLAST); end
      n_checks++; if (SRAM_CEn !== 1'b1) begin n_fail++; $display("FAIL rst_cen: got %b expected 1", SRAM_CEn); end
      n_checks++; if (SRAM_WEn !== 1'b1) begin n_fail++; $display("FAIL rst_wen: got %b expected 1", SRAM_WEn); end
      n_checks++; if (SRAM_WBEn !== 8'hFF) begin n_fail++; $display("FAIL rst_wben: got %h expected ff", SRAM_WBEn); end
      n_checks++; if (BID !== 4'h0) begin n_fail++; $display("FAIL rst_id: got %h expected 0", BID); end
      n_checks++; if (BRESP !== 2'b00) begin n_fail++; $display("FAIL rst_bresp: got %b expected 00", BRESP); end
      reset_dut();
   endtask

   task automatic test_write();
      int b0 = log_addr.size();
      wr_burst(4'h5, 32'h0A8, 8'd1, 8'hFF, 8'h0F, 64'hDEADBEEF_00000000);
      n_checks++; if (wr_tmo !== 1'b0) begin n_fail++; $display("FAIL wr_timeout: got %b expected 0", wr_tmo); end
      n_checks++; if (log_addr.size() - b0 != 2) begin n_fail++; $display("FAIL wr_strobes: got %0d expected 2", log_addr.size() - b0); end
      n_checks++; if (log_addr[b0] !== 32'h0A8) begin n_fail++; $display("FAIL wr_addr0: got %h expected 0a8", log_addr[b0]); end
      n_checks++; if (log_addr[b0+1] !== 32'h0B0) begin n_fail++; $display("FAIL wr_addr1: got %h expected 0b0", log_addr[b0+1]); end
      n_checks++; if (log_wbe[b0] !== 8'h00) begin n_fail++; $display("FAIL wr_wbe0: got %h expected 00", log_wbe[b0]); end
      n_checks++; if (log_wbe[b0+1] !== 8'hF0) begin n_fail++; $display("FAIL wr_wbe1: got %h expected f0", log_wbe[b0+1]); end
      n_checks++; if (log_wen[b0] !== 1'b0 || log_wen[b0+1] !== 1'b0) begin n_fail++; $display("FAIL wr_wen: got %b%b expected 00", log_wen[b0], log_wen[b0+1]); end
      n_checks++; if (log_data[b0+1] !== 64'hDEADBEEF_00000001) begin n_fail++; $display("FAIL wr_data1: got %h expected deadbeef00000001", log_data[b0+1]); end
      n_checks++; if (bid_got !== 4'h5) begin n_fail++; $display("FAIL wr_bid: got %h expected 5", bid_got); end
      n_checks++; if (bresp_got !== 2'b00) begin n_fail++; $display("FAIL wr_bresp: got %b expected 00", bresp_got); end
      WVALID = 1; #1;
      n_checks++; if (WREADY !== 1'b0) begin n_fail++; $display("FAIL wr_stall_extra: got %b expected 0", WREADY); end
      WVALID = 0;
      @(posedge CLK); #1;
      rd_burst(4'h3, 32'h0A8, 8'd1, -1, 0);
      n_checks++; if (rd_data[0] !== 64'hDEADBEEF_00000000) begin n_fail++; $display("FAIL wr_readback0: got %h expected deadbeef00000000", rd_data[0]); end
      n_checks++; if (rd_data[1] !== 64'h5A5A5A16_00000001) begin n_fail++; $display("FAIL wr_readback1: got %h expected 5a5a5a1600000001", rd_data[1]); end
   endtask

   task automatic test_read();
      logic [63:0] exp_d [4];
      int b0 = log_addr.size();
      exp_d[0] = 64'h5A5A5A2A_3C3C3CD5; exp_d[1] = 64'h5A5A5A2B_3C3C3CD4;
      exp_d[2] = 64'h5A5A5A2C_3C3C3CD3; exp_d[3] = 64'h5A5A5A2D_3C3C3CD2;
      rd_burst(4'h9, 32'h150, 8'd3, -1, 0);
      n_checks++; if (rd_tmo !== 1'b0) begin n_fail++; $display("FAIL rd_timeout: got %b expected 0", rd_tmo); end
      n_checks++; if (log_addr.size() - b0 != 4) begin n_fail++; $display("FAIL rd_strobes: got %0d expected 4", log_addr.size() - b0); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (log_addr[b0+i] !== 32'h150 + 32'(8*i) || log_wen[b0+i] !== 1'b1) begin n_fail++; $display("FAIL rd_strobe%0d: got %h/%b expected %h/1", i, log_addr[b0+i], log_wen[b0+i], 32'h150 + 32'(8*i)); end
         n_checks++; if (rd_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL rd_data%0d: got %h expected %h", i, rd_data[i], exp_d[i]); end
         n_checks++; if (rd_last[i] !== (i == 3)) begin n_fail++; $display("FAIL rd_last%0d: got %b expected %b", i, rd_last[i], i == 3); end
         n_checks++; if (rd_resp[i] !== 2'b00) begin n_fail++; $display("FAIL rd_resp%0d: got %b expected 00", i, rd_resp[i]); end
      end
      n_checks++; if (log_cyc[b0+3] - log_cyc[b0] != 3) begin n_fail++; $display("FAIL rd_consecutive: got %0d expected 3", log_cyc[b0+3] - log_cyc[b0]); end
      n_checks++; if (rd_id[0] !== 4'h9) begin n_fail++; $display("FAIL rd_rid: got %h expected 9", rd_id[0]); end
   endtask

   task automatic test_backpressure();
      logic [63:0] exp_d [4];
      int b0 = log_addr.size();
      exp_d[0] = 64'h5A5A5A2A_3C3C3CD5; exp_d[1] = 64'h5A5A5A2B_3C3C3CD4;
      exp_d[2] = 64'h5A5A5A2C_3C3C3CD3; exp_d[3] = 64'h5A5A5A2D_3C3C3CD2;
      rd_burst(4'h2, 32'h150, 8'd3, 1, 3);
      n_checks++; if (rd_tmo !== 1'b0) begin n_fail++; $display("FAIL bp_timeout: got %b expected 0", rd_tmo); end
      n_checks++; if (stall_data.size() != 3) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d expected 3", stall_data.size()); end
      for (int i = 0; i < stall_data.size(); i++) begin
         n_checks++; if (stall_data[i] !== exp_d[1]) begin n_fail++; $display("FAIL bp_stable%0d: got %h expected %h", i, stall_data[i], exp_d[1]); end
      end
      n_checks++; if (stall_cen_bad != 0) begin n_fail++; $display("FAIL bp_cen: got %0d strobes expected 0", stall_cen_bad); end
      n_checks++; if (log_addr.size() - b0 != 4) begin n_fail++; $display("FAIL bp_strobes: got %0d expected 4", log_addr.size() - b0); end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (rd_data[i] !== exp_d[i]) begin n_fail++; $display("FAIL bp_data%0d: got %h expected %h", i, rd_data[i], exp_d[i]); end
      end
   endtask

   task automatic test_arbitration();
      reset_dut();
      ARID = 4'h2; ARADDR = 32'h150; ARLEN = 8'd0; ARVALID = 1;
      wr_burst(4'h1, 32'h200, 8'd0, 8'hFF, 8'hFF, 64'h1234);
      n_checks++; if (aw_wait != 0 || first_ar !== 1'b0) begin n_fail++; $display("FAIL arb_first_write: got wait %0d arready %b expected 0/0", aw_wait, first_ar); end
      AWID = 4'h1; AWADDR = 32'h208; AWLEN = 8'd0; AWVALID = 1;
      rd_burst(4'h2, 32'h150, 8'd0, -1, 0);
      n_checks++; if (ar_wait != 0 || first_aw !== 1'b0) begin n_fail++; $display("FAIL arb_then_read: got wait %0d awready %b expected 0/0", ar_wait, first_aw); end
      n_checks++; if (rd_data[0] !== 64'h5A5A5A2A_3C3C3CD5) begin n_fail++; $display("FAIL arb_rdata: got %h expected 5a5a5a2a3c3c3cd5", rd_data[0]); end
      ARID = 4'h2; ARADDR = 32'h158; ARLEN = 8'd0; ARVALID = 1;
      wr_burst(4'h1, 32'h208, 8'd0, 8'hFF, 8'hFF, 64'h5678);
      n_checks++; if (aw_wait != 0 || first_ar !== 1'b0) begin n_fail++; $display("FAIL arb_write_again: got wait %0d arready %b expected 0/0", aw_wait, first_ar); end
      rd_burst(4'h2, 32'h158, 8'd0, -1, 0);
      n_checks++; if (rd_data[0] !== 64'h5A5A5A2B_3C3C3CD4) begin n_fail++; $display("FAIL arb_rdata2: got %h expected 5a5a5a2b3c3c3cd4", rd_data[0]); end
   endtask

   task automatic test_range();
      int b0 = log_addr.size();
      rd_burst(4'h4, 32'h688, 8'd1, -1, 0);
      n_checks++; if (rd_data[0] !== 64'h5A5A5AD1_3C3C3C2E || rd_resp[0] !== 2'b00) begin n_fail++; $display("FAIL rng_in_beat: got %h/%b expected 5a5a5ad13c3c3c2e/00", rd_data[0], rd_resp[0]); end
      n_checks++; if (rd_last[1] !== 1'b1) begin n_fail++; $display("FAIL rng_rlast: got %b expected 1", rd_last[1]); end
`ifdef AXI_SRAM_BRIDGE_RANGE_CHK_EN
      n_checks++; if (rd_data[1] !== 64'd0 || rd_resp[1] !== 2'b10) begin n_fail++; $display("FAIL rng_out_beat: got %h/%b expected 0/10", rd_data[1], rd_resp[1]); end
      n_checks++; if (log_addr.size() - b0 != 1) begin n_fail++; $display("FAIL rng_rd_strobes: got %0d expected 1", log_addr.size() - b0); end
      b0 = log_addr.size();
      wr_burst(4'h6, 32'h690, 8'd0, 8'hFF, 8'hFF, 64'h99);
      n_checks++; if (bresp_got !== 2'b10 || bid_got !== 4'h6) begin n_fail++; $display("FAIL rng_bresp: got %b/%h expected 10/6", bresp_got, bid_got); end
      n_checks++; if (log_addr.size() - b0 != 0) begin n_fail++; $display("FAIL rng_wr_strobes: got %0d expected 0", log_addr.size() - b0); end
      wr_burst(4'h6, 32'h680, 8'd0, 8'hFF, 8'hFF, 64'h99);
      n_checks++; if (bresp_got !== 2'b00) begin n_fail++; $display("FAIL rng_bresp_clear: got %b expected 00", bresp_got); end
`else
      n_checks++; if (rd_data[1] !== 64'h5A5A5AD2_3C3C3C2D || rd_resp[1] !== 2'b00) begin n_fail++; $display("FAIL rng_out_beat: got %h/%b expected 5a5a5ad23c3c3c2d/00", rd_data[1], rd_resp[1]); end
      n_checks++; if (log_addr.size() - b0 != 2) begin n_fail++; $display("FAIL rng_rd_strobes: got %0d expected 2", log_addr.size() - b0); end
      b0 = log_addr.size();
      wr_burst(4'h6, 32'h690, 8'd0, 8'hFF, 8'hFF, 64'h99);
      n_checks++; if (bresp_got !== 2'b00 || bid_got !== 4'h6) begin n_fail++; $display("FAIL rng_bresp: got %b/%h expected 00/6", bresp_got, bid_got); end
      n_checks++; if (log_addr.size() - b0 != 1) begin n_fail++; $display("FAIL rng_wr_strobes: got %0d expected 1", log_addr.size() - b0); end
`endif
   endtask

   task automatic test_reset_mid_burst();
      int b0 = log_addr.size();
      int n_hit;
      bit reached = 0;
      ARID = 4'h7; ARADDR = 32'h300; ARLEN = 8'd7; ARVALID = 1; RREADY = 1;
      for (int k = 0; k < 20 && !reached; k++) begin
         @(posedge CLK); #1;
         ARVALID = 0;
         if (log_addr.size() - b0 >= 3) reached = 1;
      end
      n_checks++; if (!reached) begin n_fail++; $display("FAIL rmid_reach_beat2: got %0d strobes expected 3", log_addr.size() - b0); end
      RESETn = 1'b0; #1;
      n_checks++; if (RVALID !== 1'b0) begin n_fail++; $display("FAIL rmid_rvalid: got %b expected 0", RVALID); end
      n_checks++; if (SRAM_CEn !== 1'b1) begin n_fail++; $display("FAIL rmid_cen: got %b expected 1", SRAM_CEn); end
      n_hit = log_addr.size() - b0;
      RREADY = 0;
      repeat (2) @(posedge CLK);
      #1;
      n_checks++; if (log_addr.size() - b0 != n_hit) begin n_fail++; $display("FAIL rmid_no_strobe: got %0d expected %0d", log_addr.size() - b0, n_hit); end
      RESETn = 1'b1;
      @(posedge CLK); #1;
      b0 = log_addr.size();
      rd_burst(4'h8, 32'h150, 8'd0, -1, 0);
      n_checks++; if (rd_tmo !== 1'b0) begin n_fail++; $display("FAIL rmid_next_timeout: got %b expected 0", rd_tmo); end
      n_checks++; if (rd_data[0] !== 64'h5A5A5A2A_3C3C3CD5 || rd_last[0] !== 1'b1 || rd_id[0] !== 4'h8) begin n_fail++; $display("FAIL rmid_next_read: got %h/%b/%h expected 5a5a5a2a3c3c3cd5/1/8", rd_data[0], rd_last[0], rd_id[0]); end
      n_checks++; if (log_addr.size() - b0 != 1 || log_addr[b0] !== 32'h150) begin n_fail++; $display("FAIL rmid_next_strobe: got %0d at %h expected 1 at 150", log_addr.size() - b0, log_addr[b0]); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_arbitration();
      test_range();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule
